sd_sector_bridge: RTL and testbench

- Downstream consumer of the hps_io SD block-level interface (single virtual disk, byte mode, 512-byte sectors).
- Converts a core-side sector request (LBA + read/write pulse) into the sd_rd/sd_wr/sd_ack handshake.
- Holds the sector in a local buffer that the core disk controller (floppy/SCSI) accesses at its own pace.
- Validates each request against the mounted image size and read-only flag, and reports done/error status.

---
 rtl/sd_bridge_pkg.sv | 26 ++
 rtl/sd_sector_bridge_if.sv | 23 ++
 rtl/sector_buf.sv | 24 ++
 rtl/sd_sector_bridge.sv | 184 ++++++++++++++++++
 tb/tb_sd_sector_bridge.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_bridge_pkg.sv
// Shared widths, FSM state codes and error-cause codes for the SD sector bridge.
package sd_bridge_pkg;
   localparam int unsigned SECTOR_BYTES = 512;
   localparam int unsigned SECTOR_SHIFT = 9;
   localparam int unsigned ADDR_W       = 9;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned LBA_W        = 32;
   localparam int unsigned CNT_W        = 10;
   localparam int unsigned TMO_W        = 24;
   localparam int unsigned ST_W         = 3;
   localparam int unsigned ERR_W        = 3;

   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_RREQ  = 3'd1;
   localparam logic [ST_W-1:0] ST_RXFER = 3'd2;
   localparam logic [ST_W-1:0] ST_WREQ  = 3'd3;
   localparam logic [ST_W-1:0] ST_WXFER = 3'd4;
   localparam logic [ST_W-1:0] ST_FIN   = 3'd5;

   localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
   localparam logic [ERR_W-1:0] ERR_NOIMG   = 3'd1;
   localparam logic [ERR_W-1:0] ERR_RANGE   = 3'd2;
   localparam logic [ERR_W-1:0] ERR_RO      = 3'd3;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd4;
   localparam logic [ERR_W-1:0] ERR_SHORT   = 3'd5;
endpackage

// File: rtl/sd_sector_bridge_if.sv
// hps_io SD block-level handshake and byte-buffer bus.
interface sd_sector_bridge_if;
   import sd_bridge_pkg::*;

   logic [LBA_W-1:0]  sd_lba;
   logic              sd_rd;
   logic              sd_wr;
   logic              sd_ack;
   logic [ADDR_W-1:0] sd_buff_addr;
   logic [DATA_W-1:0] sd_buff_dout;
   logic              sd_buff_wr;
   logic [DATA_W-1:0] sd_buff_din;

   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );
endinterface

// File: rtl/sector_buf.sv
// True dual-port 512x8 sector RAM, one clock, registered reads on both ports.
module sector_buf
   import sd_bridge_pkg::*;
(
   input  logic              clk,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_din,
   input  logic              a_we,
   output logic [DATA_W-1:0] a_dout,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_din,
   input  logic              b_we,
   output logic [DATA_W-1:0] b_dout
);
   logic [DATA_W-1:0] mem_q [SECTOR_BYTES];

   // Both write enables are mutually exclusive by construction in the parent.
   always_ff @(posedge clk) begin
      if (a_we) mem_q[a_addr] <= a_din;
      if (b_we) mem_q[b_addr] <= b_din;
      a_dout <= mem_q[a_addr];
      b_dout <= mem_q[b_addr];
   end
endmodule

// File: rtl/sd_sector_bridge.sv
// Bridges a core sector request onto the hps_io sd_rd/sd_wr/sd_ack handshake
// through a local sector buffer, with mount-based request validation.
module sd_sector_bridge
   import sd_bridge_pkg::*;
#(
   parameter logic [TMO_W-1:0] TIMEOUT = 24'hFFFFFF
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              img_mounted,
   input  logic              img_readonly,
   input  logic [63:0]       img_size,
   sd_sector_bridge_if.master sd,
   input  logic [LBA_W-1:0]  req_lba,
   input  logic              req_rd,
   input  logic              req_wr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ERR_W-1:0]  err_cause,
   input  logic [ADDR_W-1:0] buf_addr,
   input  logic [DATA_W-1:0] buf_din,
   input  logic              buf_we,
   output logic [DATA_W-1:0] buf_dout
);
   logic [ST_W-1:0]  state_q, state_d;
   logic [LBA_W-1:0] lba_q, lba_d;
   logic             rd_q, rd_d, wr_q, wr_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [ERR_W-1:0] cause_q, cause_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LBA_W-1:0] sectors_q, sectors_d;
   logic             mounted_q, mounted_d, ro_q, ro_d;

   logic             rx_xfer_c;
   logic             hps_we_c;
   logic [TMO_W-1:0] tmo_inc_c;

   assign rx_xfer_c = (state_q == ST_RXFER);
   assign hps_we_c  = rx_xfer_c & sd.sd_buff_wr;
   assign tmo_inc_c = tmo_q + TMO_W'(1);

   always_comb begin
      state_d   = state_q;
      lba_d     = lba_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      cause_d   = cause_q;
      tmo_d     = tmo_q;
      cnt_d     = cnt_q;
      sectors_d = sectors_q;
      mounted_d = mounted_q;
      ro_d      = ro_q;

      // Mount updates apply independently of any operation in flight.
      if (img_mounted) begin
         mounted_d = (img_size != 64'd0);
         ro_d      = img_readonly;
         sectors_d = img_size[SECTOR_SHIFT +: LBA_W];
      end

      case (state_q)
         ST_IDLE: begin
            if (req_rd || req_wr) begin
               lba_d  = req_lba;
               busy_d = 1'b1;
               err_d  = 1'b1;
               tmo_d  = '0;
               if (!mounted_q) begin
                  cause_d = ERR_NOIMG;
                  state_d = ST_FIN;
               end else if (req_lba >= sectors_q) begin
                  cause_d = ERR_RANGE;
                  state_d = ST_FIN;
               end else if (!req_rd && ro_q) begin
                  cause_d = ERR_RO;
                  state_d = ST_FIN;
               end else begin
                  err_d   = 1'b0;
                  cause_d = ERR_NONE;
                  rd_d    = req_rd;
                  wr_d    = !req_rd;
                  state_d = req_rd ? ST_RREQ : ST_WREQ;
               end
            end
         end
         ST_RREQ, ST_WREQ: begin
            if (sd.sd_ack) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               cnt_d   = '0;
               state_d = (state_q == ST_RREQ) ? ST_RXFER : ST_WXFER;
            end else if (tmo_inc_c == TIMEOUT) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               err_d   = 1'b1;
               cause_d = ERR_TIMEOUT;
               state_d = ST_FIN;
            end else begin
               tmo_d = tmo_inc_c;
            end
         end
         ST_RXFER: begin
            if (hps_we_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
            // A strobe coinciding with the ack fall still counts toward the sector.
            if (!sd.sd_ack) begin
               err_d   = (cnt_d != CNT_W'(SECTOR_BYTES));
               cause_d = (cnt_d != CNT_W'(SECTOR_BYTES)) ? ERR_SHORT : ERR_NONE;
               state_d = ST_FIN;
            end
         end
         ST_WXFER: begin
            if (!sd.sd_ack) begin
               err_d   = 1'b0;
               cause_d = ERR_NONE;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         lba_q     <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cause_q   <= ERR_NONE;
         tmo_q     <= '0;
         cnt_q     <= '0;
         sectors_q <= '0;
         mounted_q <= 1'b0;
         ro_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         lba_q     <= lba_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cause_q   <= cause_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         sectors_q <= sectors_d;
         mounted_q <= mounted_d;
         ro_q      <= ro_d;
      end
   end

   assign sd.sd_lba = lba_q;
   assign sd.sd_rd  = rd_q;
   assign sd.sd_wr  = wr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_cause = cause_q;

   // HPS owns the buffer during a read transfer; core writes are dropped then.
   sector_buf u_buf (
      .clk    (clk_sys),
      .a_addr (buf_addr),
      .a_din  (buf_din),
      .a_we   (buf_we & ~rx_xfer_c),
      .a_dout (buf_dout),
      .b_addr (sd.sd_buff_addr),
      .b_din  (sd.sd_buff_dout),
      .b_we   (hps_we_c),
      .b_dout (sd.sd_buff_din)
   );
endmodule

// File: tb/tb_sd_sector_bridge.sv
// Self-checking bench: hps_io and core models driven with randomized data,
// checked against a sector-level reference model of mount state and buffer.
module tb_sd_sector_bridge;
   import sd_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        img_mounted, img_readonly;
   logic [63:0] img_size;
   logic [31:0] req_lba;
   logic        req_rd, req_wr;
   logic        busy, done, err;
   logic [2:0]  err_cause;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_din;
   logic        buf_we;
   logic [7:0]  buf_dout;

   sd_sector_bridge_if sd_if ();

   sd_sector_bridge #(.TIMEOUT(24'd100)) dut (
      .clk_sys (clk), .reset_n (rst_n),
      .img_mounted (img_mounted), .img_readonly (img_readonly), .img_size (img_size),
      .sd (sd_if),
      .req_lba (req_lba), .req_rd (req_rd), .req_wr (req_wr),
      .busy (busy), .done (done), .err (err), .err_cause (err_cause),
      .buf_addr (buf_addr), .buf_din (buf_din), .buf_we (buf_we), .buf_dout (buf_dout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: mount state and buffer contents
   bit          m_mounted = 0;
   bit          m_ro = 0;
   logic [31:0] m_sectors = 0;
   logic [7:0]  m_mem [512];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mount(input logic [63:0] size, input bit ro);
      img_mounted = 1'b1; img_size = size; img_readonly = ro;
      tick();
      img_mounted = 1'b0;
      m_mounted = (size != 0);
      m_ro      = ro;
      m_sectors = 32'(size / 512);
   endtask

   task automatic send_req(input bit rd, input bit wr, input logic [31:0] lba);
      req_rd = rd; req_wr = wr; req_lba = lba;
      tick();
      req_rd = 1'b0; req_wr = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1) begin seen = 1; break; end
      end
   endtask

   task automatic core_fill(input int n, input bit ramp);
      for (int i = 0; i < n; i++) begin
         logic [8:0] a;
         logic [7:0] d;
         a = ramp ? 9'(i) : 9'($urandom_range(0, 511));
         d = ramp ? 8'(i) : 8'($urandom);
         buf_we = 1'b1; buf_addr = a; buf_din = d;
         m_mem[a] = d;
         tick();
      end
      buf_we = 1'b0;
   endtask

   // hps_io side of a read: request check, ack, nbytes strobes, ack fall
   task automatic hps_read(input int delay, input int nbytes, input bit pattern,
                           input logic [31:0] lba, input string name);
      n_tests++;
      if (sd_if.sd_rd !== 1'b1 || sd_if.sd_lba !== lba) begin
         n_fail++;
         $display("FAIL %s_req: sd_rd=%b sd_lba=%0d, required sd_rd=1 sd_lba=%0d",
                  name, sd_if.sd_rd, sd_if.sd_lba, lba);
      end
      repeat (delay) tick();
      sd_if.sd_ack = 1'b1;
      tick();
      n_tests++;
      if (sd_if.sd_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_rd_drop: sd_rd=%b, required 0", name, sd_if.sd_rd);
      end
      for (int i = 0; i < nbytes; i++) begin
         logic [7:0] d;
         d = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
         sd_if.sd_buff_wr = 1'b1; sd_if.sd_buff_addr = 9'(i); sd_if.sd_buff_dout = d;
         m_mem[i % 512] = d;
         tick();
      end
      sd_if.sd_buff_wr = 1'b0;
      sd_if.sd_ack = 1'b0;
   endtask

   // hps_io side of a write: request check, ack, stream 512 bytes out of the buffer
   task automatic hps_write(input int delay, input logic [31:0] lba, input string name);
      int bad;
      n_tests++;
      if (sd_if.sd_wr !== 1'b1 || sd_if.sd_lba !== lba) begin
         n_fail++;
         $display("FAIL %s_req: sd_wr=%b sd_lba=%0d, required sd_wr=1 sd_lba=%0d",
                  name, sd_if.sd_wr, sd_if.sd_lba, lba);
      end
      repeat (delay) tick();
      sd_if.sd_ack = 1'b1;
      tick();
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         sd_if.sd_buff_addr = 9'(i);
         tick();
         if (sd_if.sd_buff_din !== m_mem[i]) bad++;
      end
      n_tests++;
      if (bad != 0 || sd_if.sd_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_data: %0d bytes differ, sd_wr=%b, required 0 differ, sd_wr=0",
                  name, bad, sd_if.sd_wr);
      end
      sd_if.sd_ack = 1'b0;
   endtask

   // One request, outcome predicted from the model's mount state
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] lba, input string name);
      bit         acc, seen, saw_req;
      logic [2:0] exp_cause;
      logic [8:0] a;
      if (!m_mounted)             exp_cause = ERR_NOIMG;
      else if (lba >= m_sectors)  exp_cause = ERR_RANGE;
      else if (!rd && m_ro)       exp_cause = ERR_RO;
      else                        exp_cause = ERR_NONE;
      acc = (exp_cause == ERR_NONE);
      send_req(rd, wr, lba);
      if (!acc) begin
         saw_req = sd_if.sd_rd | sd_if.sd_wr;
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_rej_busy: done=%b busy=%b, required done=0 busy=1", name, done, busy);
         end
         tick();
         saw_req |= sd_if.sd_rd | sd_if.sd_wr;
         n_tests++;
         if (done !== 1'b1 || err !== 1'b1 || err_cause !== exp_cause || saw_req || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rej: done=%b err=%b cause=%0d req_seen=%b busy=%b, required 1 1 %0d 0 0",
                     name, done, err, err_cause, saw_req, busy, exp_cause);
         end
      end else begin
         if (rd) hps_read($urandom_range(1, 20), 512, 0, lba, name);
         else    hps_write($urandom_range(1, 20), lba, name);
         wait_done(seen);
         n_tests++;
         if (!seen || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: seen=%b err=%b busy=%b, required 1 0 0", name, seen, err, busy);
         end
         a = 9'($urandom_range(0, 511));
         buf_addr = a;
         tick();
         n_tests++;
         if (buf_dout !== m_mem[a]) begin
            n_fail++;
            $display("FAIL %s_buf[%0d]: got %h, required %h", name, a, buf_dout, m_mem[a]);
         end
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if (busy !== 0 || done !== 0 || err !== 0 || sd_if.sd_rd !== 0 || sd_if.sd_wr !== 0
          || sd_if.sd_lba !== 32'd0) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b err=%b rd=%b wr=%b lba=%0d, required all 0",
                  busy, done, err, sd_if.sd_rd, sd_if.sd_wr, sd_if.sd_lba);
      end
   endtask

   task automatic test_read_basic();
      bit seen;
      mount(64'd1 << 20, 1'b0);
      send_req(1'b1, 1'b0, 32'd5);
      hps_read(20, 512, 1, 32'd5, "rd_basic");
      wait_done(seen);
      n_tests++;
      if (!seen || err !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_basic_done: seen=%b err=%b, required 1 0", seen, err);
      end
      buf_addr = 9'd3;
      tick();
      n_tests++;
      if (buf_dout !== 8'h59) begin
         n_fail++;
         $display("FAIL rd_basic_buf3: got %h, required 59", buf_dout);
      end
   endtask

   task automatic test_write_last();
      bit seen;
      core_fill(512, 1);
      send_req(1'b0, 1'b1, 32'd2047);
      hps_write(7, 32'd2047, "wr_last");
      wait_done(seen);
      n_tests++;
      if (!seen || err !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_last_done: seen=%b err=%b, required 1 0", seen, err);
      end
   endtask

   task automatic test_reject();
      mount(64'd1 << 20, 1'b0);
      do_op(1'b1, 1'b0, 32'd2048, "range");
      mount(64'd0, 1'b0);
      do_op(1'b1, 1'b0, 32'd0, "noimg");
      mount(64'd1 << 20, 1'b1);
      do_op(1'b0, 1'b1, 32'd10, "ro_wr");
      do_op(1'b1, 1'b0, 32'd7, "ro_rd");
      mount((64'd1 << 20) + 64'd300, 1'b0);
      do_op(1'b1, 1'b0, 32'd2048, "partial");
      do_op(1'b1, 1'b1, 32'd2047, "rd_wins");
   endtask

   task automatic test_timeout();
      int cnt;
      bit seen;
      mount(64'd1 << 20, 1'b0);
      send_req(1'b1, 1'b0, 32'd9);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (sd_if.sd_rd !== 1'b1) break;
         cnt++;
         tick();
      end
      n_tests++;
      if (cnt != 100) begin
         n_fail++;
         $display("FAIL timeout_len: sd_rd high %0d cycles, required 100", cnt);
      end
      wait_done(seen);
      n_tests++;
      if (!seen || err !== 1'b1 || err_cause !== ERR_TIMEOUT) begin
         n_fail++;
         $display("FAIL timeout_done: seen=%b err=%b cause=%0d, required 1 1 %0d",
                  seen, err, err_cause, ERR_TIMEOUT);
      end
   endtask

   task automatic test_short();
      bit seen;
      logic [7:0] keep;
      send_req(1'b1, 1'b0, 32'd12);
      sd_if.sd_ack = 1'b1;
      tick();
      keep = m_mem[450];
      for (int i = 0; i < 300; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         sd_if.sd_buff_wr = 1'b1; sd_if.sd_buff_addr = 9'(i); sd_if.sd_buff_dout = d;
         m_mem[i] = d;
         // core write during the read transfer must be dropped
         buf_we = (i == 10); buf_addr = 9'd450; buf_din = ~keep;
         tick();
      end
      buf_we = 1'b0;
      sd_if.sd_buff_wr = 1'b0;
      sd_if.sd_ack = 1'b0;
      wait_done(seen);
      n_tests++;
      if (!seen || err !== 1'b1 || err_cause !== ERR_SHORT) begin
         n_fail++;
         $display("FAIL short_done: seen=%b err=%b cause=%0d, required 1 1 %0d",
                  seen, err, err_cause, ERR_SHORT);
      end
      buf_addr = 9'd450;
      tick();
      n_tests++;
      if (buf_dout !== m_mem[450]) begin
         n_fail++;
         $display("FAIL short_core_we: buf[450]=%h, required %h", buf_dout, m_mem[450]);
      end
   endtask

   task automatic test_busy_ignored();
      bit seen;
      sd_if.sd_ack = 1'b1;
      repeat (3) tick();
      n_tests++;
      if (busy !== 1'b0 || sd_if.sd_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_ack: busy=%b sd_rd=%b, required 0 0", busy, sd_if.sd_rd);
      end
      sd_if.sd_ack = 1'b0;
      send_req(1'b1, 1'b0, 32'd4);
      send_req(1'b0, 1'b1, 32'd9);
      n_tests++;
      if (sd_if.sd_lba !== 32'd4 || sd_if.sd_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_req: sd_lba=%0d sd_wr=%b, required 4 0", sd_if.sd_lba, sd_if.sd_wr);
      end
      hps_read(3, 512, 0, 32'd4, "busy_rd");
      wait_done(seen);
      n_tests++;
      if (!seen || err !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_rd_done: seen=%b err=%b, required 1 0", seen, err);
      end
   endtask

   task automatic test_reset_mid();
      send_req(1'b1, 1'b0, 32'd3);
      sd_if.sd_ack = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         sd_if.sd_buff_wr = 1'b1; sd_if.sd_buff_addr = 9'(i); sd_if.sd_buff_dout = d;
         m_mem[i] = d;
         tick();
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || sd_if.sd_rd !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: busy=%b sd_rd=%b done=%b err=%b, required 0 0 0 0",
                  busy, sd_if.sd_rd, done, err);
      end
      // strobes after reset must not land in the buffer
      for (int i = 100; i < 150; i++) begin
         sd_if.sd_buff_addr = 9'(i); sd_if.sd_buff_dout = ~m_mem[i];
         tick();
      end
      sd_if.sd_buff_wr = 1'b0;
      sd_if.sd_ack = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      buf_addr = 9'd120;
      tick();
      n_tests++;
      if (buf_dout !== m_mem[120]) begin
         n_fail++;
         $display("FAIL rst_drop: buf[120]=%h, required %h", buf_dout, m_mem[120]);
      end
      m_mounted = 0; m_ro = 0; m_sectors = 0;
      mount(64'd1 << 20, 1'b0);
      do_op(1'b1, 1'b0, 32'd3, "after_rst");
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         logic [31:0] lba;
         bit rd, wr;
         case ($urandom_range(0, 3))
            0: mount(64'd1 << 20, 1'($urandom));
            1: mount((64'd1 << 16) + 64'($urandom_range(0, 511)), 1'($urandom));
            2: mount(64'd0, 1'b0);
            default: mount(64'($urandom_range(512, 1 << 22)), 1'($urandom));
         endcase
         core_fill(8, 0);
         case ($urandom_range(0, 3))
            0: lba = m_sectors - 32'd1;
            1: lba = m_sectors;
            2: lba = (m_sectors == 0) ? 32'd0 : 32'($urandom_range(0, m_sectors - 1));
            default: lba = $urandom;
         endcase
         rd = 1'($urandom);
         wr = rd ? 1'($urandom) : 1'b1;
         do_op(rd, wr, lba, $sformatf("rand%0d", it));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      img_mounted = 0; img_readonly = 0; img_size = '0;
      req_lba = '0; req_rd = 0; req_wr = 0;
      buf_addr = '0; buf_din = '0; buf_we = 0;
      sd_if.sd_ack = 0; sd_if.sd_buff_addr = '0; sd_if.sd_buff_dout = '0; sd_if.sd_buff_wr = 0;
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_read_basic();
      test_write_last();
      test_reject();
      test_timeout();
      test_short();
      test_busy_ignored();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
